fifo_ddr_wr_sched: RTL
======================

// Module: fifo_ddr_wr_sched
// PURPOSE
//  Read-side burst scheduler for the 32->128 async prefetch FIFO: drains 128-bit words from the FIFO
//  read port and issues them as address+burst write transactions to the DDR write channel.
//  Tracks frame write address from BASE_ADDR, splits the frame into BURST_LEN-beat bursts (short last burst),
//  restarts on frame_start. Sits between the FIFO read port and the DDR controller write port.
// PARAMETERS
//  DATA_WIDTH   128     FIFO read / DDR write data width
//  ADDR_WIDTH   28      DDR command address width
//  BURST_LEN    16      beats per full burst, 1..256
//  BEAT_ADDR    8       address increment per beat (DDR address units per 128-bit word)
//  BASE_ADDR    0       frame start address
//  FRAME_BEATS  230400  128-bit beats per frame (1280x720x32b)
// PORTS
//  rd_clk         in   1           single clock (FIFO read-side clock)
//  rd_rst         in   1           asynchronous active-high reset
//  enable         in   1           allow new bursts; sampled only in IDLE
//  frame_start    in   1           1-cycle pulse: restart frame at BASE_ADDR
//  fifo_rd_vld    in   1           FIFO head word valid
//  fifo_rd_data   in   DATA_WIDTH  FIFO head word
//  fifo_rd_en     out  1           pop FIFO head (combinational)
//  cmd_valid      out  1           write command valid
//  cmd_ready      in   1           command accepted
//  cmd_addr       out  ADDR_WIDTH  burst start address
//  cmd_len        out  8           burst length minus 1
//  wdata_valid    out  1           write beat valid
//  wdata_ready    in   1           write beat accepted
//  wdata          out  DATA_WIDTH  write beat = fifo_rd_data
//  wdata_last     out  1           final beat of burst
//  frame_done     out  1           1-cycle pulse after last beat of frame accepted
//  busy           out  1           state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, addr=BASE_ADDR, beats_left=0, frame_active=0, start_pend=0; all outputs 0.
//  - frame_start sets start_pend (multiple pulses collapse to one); applied only in IDLE: addr<=BASE_ADDR,
//    beats_left<=FRAME_BEATS, frame_active<=1, start_pend<=0. Never aborts an in-flight burst.
//  - States: IDLE -> CMD -> DATA -> IDLE.
//  - IDLE: if start_pend, apply it (1 cycle, stay IDLE). Else if enable & frame_active & fifo_rd_vld -> CMD,
//    latching blen = min(BURST_LEN, beats_left).
//  - CMD: cmd_valid=1, cmd_addr=addr, cmd_len=blen-1, held stable until cmd_ready; on cmd_valid&cmd_ready -> DATA.
//  - DATA: wdata_valid=fifo_rd_vld, wdata=fifo_rd_data, fifo_rd_en=fifo_rd_vld&wdata_ready (one pop per
//    accepted beat, zero latency); beat counter counts accepted beats; wdata_last=1 when count==blen-1.
//    FIFO empty mid-burst: wdata_valid=0, wait, no timeout. Last beat accepted -> IDLE,
//    addr<=addr+blen*BEAT_ADDR, beats_left<=beats_left-blen.
//  - If beats_left becomes 0: frame_active<=0, frame_done=1 for that one cycle; further FIFO data is left
//    unread until next frame_start.
//  - fifo_rd_en is 0 outside DATA; no pops while cmd outstanding.
//  - enable deasserted in CMD/DATA: current burst completes normally.
//  - Address arithmetic modulo 2^ADDR_WIDTH (wraps silently).
//  - Reset mid-burst: immediate return to reset state; partial burst abandoned (downstream also reset).
// TESTING
//  1 Reset, frame_start, 32 words preloaded, ready=1 -> 2 cmds addr 0/128 len 15; 32 pops, wdata_last on beats 16,32.
//  2 FRAME_BEATS=20 -> cmds len 15 then len 3 at addr 128; frame_done pulse after beat 20; 21st word not popped.
//  3 cmd_ready low 5 cycles -> cmd_valid/addr/len stable, fifo_rd_en=0 throughout.
//  4 fifo_rd_vld drops for 3 cycles mid-burst, wdata_ready toggling -> pops == accepted beats, data order kept.
//  5 frame_start pulsed at beat 7 of burst 3 -> burst 3 completes; next cmd addr=BASE_ADDR, full frame count.
//  6 enable=0 with data waiting -> no cmd; rd_rst asserted in DATA -> all outputs 0 next edge.

Source files
------------

// File: rtl/fifo_ddr_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ddr_wr_sched
// Purpose  : Drains 128-bit prefetch-FIFO words into DDR address+burst writes,
//            walking the frame from BASE_ADDR in BURST_LEN-beat bursts.
// Revision : 1.0  initial release
// ============================================================================
module fifo_ddr_wr_sched #(
    parameter int          DATA_WIDTH  = 128,
    parameter int          ADDR_WIDTH  = 28,
    parameter int          BURST_LEN   = 16,
    parameter int          BEAT_ADDR   = 8,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          FRAME_BEATS = 230400
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic                  fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    output logic                  wdata_valid,
    input  logic                  wdata_ready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_last,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int BEATS_W = $clog2(FRAME_BEATS + 1);
    localparam logic [BEATS_W-1:0]    FRAME_BEATS_V = BEATS_W'(FRAME_BEATS);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR_V   = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEATS_W-1:0]    beats_left_q, beats_left_d;
    logic                  frame_active_q, frame_active_d;
    logic                  start_pend_q, start_pend_d;
    logic [8:0]            blen_q, blen_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  frame_done_q, frame_done_d;

    logic                  w_launch;
    logic                  w_beat_acc;
    logic                  w_beat_last;
    logic [8:0]            w_blen_next;
    logic [7:0]            w_blen_m1;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [BEATS_W-1:0]    w_left_after;

    // A pending restart always wins over launching a new burst.
    assign w_launch     = !start_pend_q && enable && frame_active_q && fifo_rd_vld;
    assign w_beat_acc   = (state_q == ST_DATA) && fifo_rd_vld && wdata_ready;
    assign w_blen_m1    = 8'(blen_q - 9'd1);
    assign w_beat_last  = (beat_cnt_q == w_blen_m1);
    assign w_addr_inc   = ADDR_WIDTH'(32'(blen_q) * 32'(BEAT_ADDR));
    assign w_left_after = beats_left_q - BEATS_W'(blen_q);

    always_comb begin
        w_blen_next = 9'(BURST_LEN);
        if (32'(beats_left_q) < 32'(BURST_LEN)) begin
            w_blen_next = 9'(beats_left_q);
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_launch)                   state_d = ST_CMD;
            ST_CMD:  if (cmd_ready)                  state_d = ST_DATA;
            ST_DATA: if (w_beat_acc && w_beat_last)  state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    // ---------------- frame / burst bookkeeping ----------------
    always_comb begin
        addr_d         = addr_q;
        beats_left_d   = beats_left_q;
        frame_active_d = frame_active_q;
        start_pend_d   = start_pend_q | frame_start;
        blen_d         = blen_q;
        beat_cnt_d     = beat_cnt_q;
        frame_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pend_q) begin
                    addr_d         = BASE_ADDR_V;
                    beats_left_d   = FRAME_BEATS_V;
                    frame_active_d = 1'b1;
                    start_pend_d   = 1'b0;
                end else if (w_launch) begin
                    blen_d     = w_blen_next;
                    beat_cnt_d = 8'd0;
                end
            end
            ST_DATA: begin
                if (w_beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (w_beat_last) begin
                        addr_d       = addr_q + w_addr_inc;
                        beats_left_d = w_left_after;
                        if (w_left_after == '0) begin
                            frame_active_d = 1'b0;
                            frame_done_d   = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            addr_q         <= BASE_ADDR_V;
            beats_left_q   <= '0;
            frame_active_q <= 1'b0;
            start_pend_q   <= 1'b0;
            blen_q         <= 9'd0;
            beat_cnt_q     <= 8'd0;
            frame_done_q   <= 1'b0;
        end else begin
            addr_q         <= addr_d;
            beats_left_q   <= beats_left_d;
            frame_active_q <= frame_active_d;
            start_pend_q   <= start_pend_d;
            blen_q         <= blen_d;
            beat_cnt_q     <= beat_cnt_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = 8'd0;
        wdata_valid = 1'b0;
        wdata       = '0;
        wdata_last  = 1'b0;
        fifo_rd_en  = 1'b0;
        case (state_q)
            ST_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = addr_q;
                cmd_len   = w_blen_m1;
            end
            ST_DATA: begin
                wdata_valid = fifo_rd_vld;
                wdata       = fifo_rd_data;
                wdata_last  = w_beat_last;
                fifo_rd_en  = w_beat_acc;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
